// File: rtl/audio_sample_sink.sv
// audio_sample_sink: box-car decimator (2^DECIM_LOG2 : 1) with an offset-binary
// to two's-complement conversion, followed by a show-ahead FIFO that the host
// drains over a valid/ready handshake.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   clk_3MHz_en    sample strobe; in_sample is valid when high
//   in_sample      16-bit offset-binary mixer sample (0x8000 = silence)
//   sound_enable   when low, the sample is replaced by silence
//   clear          synchronous flush of accumulator, phase, FIFO and flags
//   out_data       signed FIFO head (registered), valid when out_valid
//   out_valid      FIFO not empty
//   out_ready      host accepts the head this cycle
//   level          FIFO occupancy 0..D
//   overflow       sticky: a decimated word was dropped on a full FIFO
//   underrun       sticky: out_ready seen while out_valid was low
module audio_sample_sink #(
  parameter int unsigned DECIM_LOG2 = 6,
  parameter int unsigned FIFO_LOG2  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_3MHz_en,
  input  logic [15:0]          in_sample,
  input  logic                 sound_enable,
  input  logic                 clear,
  output logic [15:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [FIFO_LOG2:0]   level,
  output logic                 overflow,
  output logic                 underrun
);

  localparam int unsigned ACC_W = 16 + DECIM_LOG2;
  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned LVL_W = FIFO_LOG2 + 1;

  // Decimator state and the one-word push stage feeding the FIFO
  logic [ACC_W-1:0]      acc_q;
  logic [DECIM_LOG2-1:0] phase_q;
  logic                  push_q;
  logic [15:0]           push_word_q;

  logic [15:0]           sample_c;
  logic [ACC_W-1:0]      sum_c;
  logic [ACC_W-1:0]      avg_c;
  logic                  last_c;

  // FIFO state
  logic [15:0]           mem [DEPTH];
  logic [FIFO_LOG2-1:0]  wr_ptr_q;
  logic [FIFO_LOG2-1:0]  rd_ptr_q;

  logic                  pop_c;
  logic                  full_c;
  logic                  wr_c;
  logic                  drop_c;
  logic [LVL_W-1:0]      level_n_c;
  logic [FIFO_LOG2-1:0]  rd_ptr_n_c;
  logic [15:0]           head_n_c;

  // Effective sample, running sum and average of the completed period
  always_comb begin
    sample_c = sound_enable ? in_sample : 16'h8000;
    sum_c    = acc_q + ACC_W'(sample_c);
    avg_c    = sum_c >> DECIM_LOG2;
    last_c   = (phase_q == DECIM_LOG2'(DEPTH * 0 + (1 << DECIM_LOG2) - 1));
  end

  // Accumulate N samples; on the last one register the converted average
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      phase_q     <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else if (clear) begin
      acc_q       <= '0;
      phase_q     <= '0;
      push_q      <= 1'b0;
      push_word_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (clk_3MHz_en) begin
        if (last_c) begin
          acc_q       <= '0;
          phase_q     <= '0;
          push_q      <= 1'b1;
          push_word_q <= avg_c[15:0] ^ 16'h8000;
        end else begin
          acc_q   <= sum_c;
          phase_q <= phase_q + DECIM_LOG2'(1);
        end
      end
    end
  end

  // FIFO next-state: a pop frees a slot, so a push on a full FIFO is kept then
  always_comb begin
    pop_c      = out_valid && out_ready;
    full_c     = (level == LVL_W'(DEPTH));
    wr_c       = push_q && (!full_c || pop_c);
    drop_c     = push_q && full_c && !pop_c;
    level_n_c  = level;
    rd_ptr_n_c = rd_ptr_q;
    if (wr_c && !pop_c) begin
      level_n_c = level + LVL_W'(1);
    end else if (!wr_c && pop_c) begin
      level_n_c = level - LVL_W'(1);
    end
    if (pop_c) begin
      rd_ptr_n_c = rd_ptr_q + FIFO_LOG2'(1);
    end
    // The word being written becomes the head only when it is the sole entry
    head_n_c = 16'h0000;
    if (level_n_c != '0) begin
      if (wr_c && (wr_ptr_q == rd_ptr_n_c)) begin
        head_n_c = push_word_q;
      end else begin
        head_n_c = mem[rd_ptr_n_c];
      end
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_c && !clear) begin
      mem[wr_ptr_q] <= push_word_q;
    end
  end

  // Pointers, occupancy, registered head and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
    end else if (clear) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overflow  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (wr_c) begin
        wr_ptr_q <= wr_ptr_q + FIFO_LOG2'(1);
      end
      rd_ptr_q  <= rd_ptr_n_c;
      level     <= level_n_c;
      out_valid <= (level_n_c != '0);
      out_data  <= head_n_c;
      if (drop_c) begin
        overflow <= 1'b1;
      end
      if (out_ready && !out_valid) begin
        underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_sink.sv
// Directed bench for audio_sample_sink: a queue-level model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_audio_sample_sink;

  localparam int N = 64;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_3MHz_en;
  logic [15:0] in_sample;
  logic        sound_enable;
  logic        clear;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        overflow;
  logic        underrun;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  audio_sample_sink #(.DECIM_LOG2(6), .FIFO_LOG2(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_3MHz_en  (clk_3MHz_en),
    .in_sample    (in_sample),
    .sound_enable (sound_enable),
    .clear        (clear),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .overflow     (overflow),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: sample stream -> period averages -> delayed by one clk -> FIFO queue
  logic [15:0] mq[$];
  int unsigned msum;
  int          mcnt;
  logic        mpend;
  logic [15:0] mword;
  logic        movf;
  logic        mund;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      mq.delete();
      msum = 0; mcnt = 0; mpend = 1'b0; mword = '0; movf = 1'b0; mund = 1'b0;
    end else begin
      logic        pop;
      logic [31:0] avg;
      pop = out_ready && (mq.size() != 0);
      if (out_ready && mq.size() == 0) mund = 1'b1;
      if (pop) void'(mq.pop_front());
      if (mpend) begin
        if (mq.size() == D) movf = 1'b1;
        else mq.push_back(mword);
      end
      mpend = 1'b0;
      if (clk_3MHz_en) begin
        msum += sound_enable ? in_sample : 16'h8000;
        mcnt++;
        if (mcnt == N) begin
          avg   = msum / N;
          mword = avg[15:0] ^ 16'h8000;
          mpend = 1'b1;
          msum  = 0;
          mcnt  = 0;
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    check("m_valid", 32'(out_valid), 32'(mq.size() != 0));
    check("m_level", 32'(level), 32'(mq.size()));
    if (mq.size() != 0) check("m_data", 32'(out_data), 32'(mq[0]));
    check("m_overflow", 32'(overflow), 32'(movf));
    check("m_underrun", 32'(underrun), 32'(mund));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v, input int n, input logic se);
    for (int i = 0; i < n; i++) begin
      clk_3MHz_en  = 1'b1;
      in_sample    = v;
      sound_enable = se;
      tick();
    end
    clk_3MHz_en  = 1'b0;
    sound_enable = 1'b1;
  endtask

  task automatic pop_chk(input string name, input logic [15:0] exp);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check(name, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_3MHz_en = 1'b0; in_sample = 16'h8000;
    sound_enable = 1'b1; clear = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_data", 32'(out_data), 32'h0000);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_und", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // Silence: one 0x0000 entry, visible one clk after the 64th enable
    send(16'h8000, N, 1'b1);
    check("sil_pre_valid", 32'(out_valid), 32'd0);
    tick();
    check("sil_level", 32'(level), 32'd1);
    pop_chk("sil_data", 16'h0000);

    // Ramp, then two constants
    for (int k = 0; k < N; k++) send(16'(16'h8000 + k), 1, 1'b1);
    send(16'hC000, N, 1'b1);
    send(16'h0000, N, 1'b1);
    tick();
    check("ramp_level", 32'(level), 32'd3);
    pop_chk("ramp", 16'h001F);
    pop_chk("c000", 16'h4000);
    pop_chk("zero", 16'h8000);
    check("ramp_empty", 32'(out_valid), 32'd0);

    // Overflow: nine periods into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) send(16'(16'h8000 + i * 256), N, 1'b1);
    tick();
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 1; i <= 8; i++) pop_chk("ovf_pop", 16'(i * 256));
    check("ovf_empty", 32'(out_valid), 32'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);

    // Full FIFO with a pop on the push edge
    for (int i = 1; i <= 8; i++) send(16'(16'h8000 + i * 16), N, 1'b1);
    send(16'h8099, N, 1'b1);
    check("full_level_pre", 32'(level), 32'd8);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("full_level", 32'(level), 32'd8);
    check("full_ovf", 32'(overflow), 32'd0);
    for (int i = 2; i <= 8; i++) pop_chk("full_pop", 16'(i * 16));
    pop_chk("full_last", 16'h0099);

    // Reset mid-period discards the partial sum
    send(16'hFFFF, 30, 1'b1);
    rst_n = 1'b0;
    tick();
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_level", 32'(level), 32'd0);
    check("mrst_data", 32'(out_data), 32'h0000);
    rst_n = 1'b1;
    send(16'h8000, N, 1'b1);
    tick();
    check("mrst_one", 32'(level), 32'd1);
    pop_chk("mrst_data", 16'h0000);

    // Gating, underrun stickiness, clear
    send(16'hFFFF, N, 1'b0);
    tick();
    pop_chk("gate", 16'h0000);
    check("und_pre", 32'(underrun), 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("und_set", 32'(underrun), 32'd1);
    repeat (3) tick();
    check("und_sticky", 32'(underrun), 32'd1);

    // Clear on the push edge loses the push
    send(16'h9234, N, 1'b1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_level", 32'(level), 32'd0);
    check("clr_valid", 32'(out_valid), 32'd0);
    check("clr_und", 32'(underrun), 32'd0);
    repeat (3) tick();
    check("clr_still_empty", 32'(level), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/audio_sample_sink.md
# audio_sample_sink

Consumer end of the mixed-audio path. Takes the 16-bit offset-binary mixer sample presented at the 3 MHz enable rate, box-car decimates it to the host rate (64:1, 3.072 MHz → 48 kHz), converts it to two's complement, and buffers it in a small FIFO. The FIFO is drained by the host audio interface over a valid/ready handshake. Sits between the audio mixer output and the framework audio port.

## Interface
- DECIM_LOG2, default 6: log2 of the decimation ratio; ratio N = 2^DECIM_LOG2.
- FIFO_LOG2, default 3: log2 of FIFO depth; depth D = 2^FIFO_LOG2.

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- clk_3MHz_en  in  1  sample strobe, one clk wide; in_sample is valid when high.
- in_sample  in  16  mixer output, offset binary; 0x8000 is silence.
- sound_enable  in  1  when low, in_sample is replaced by 0x8000.
- clear  in  1  synchronous flush: accumulator, phase counter, FIFO and flags.
- out_data  out  16  signed two's-complement FIFO head; valid only when out_valid is high.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  host accepts the head this cycle.
- level  out  FIFO_LOG2+1  current FIFO occupancy, 0..D.
- overflow  out  1  sticky: a decimated sample was dropped because the FIFO was full.
- underrun  out  1  sticky: out_ready was high while out_valid was low.

## Operation
- Reset, or clear high, forces: acc=0, phase=0, FIFO empty, level=0, out_valid=0, out_data=0x0000, overflow=0, underrun=0. clear has priority over all other activity in that cycle.
- Effective sample s = sound_enable ? in_sample : 0x8000.
- Accumulator width is 16+DECIM_LOG2 bits unsigned. It cannot overflow.
- On each clk_3MHz_en:
  - phase < N-1: acc <= acc + s, phase <= phase + 1.
  - phase == N-1: sum = acc + s; avg = sum >> DECIM_LOG2 (truncating floor); pushed word = avg ^ 0x8000 (MSB inverted, offset to signed). Then acc <= 0, phase <= 0, and a push is issued.
- Push when level == D and no pop occurs in the same cycle: the word is discarded, overflow <= 1, and FIFO contents are unchanged.
- Pop occurs when out_valid && out_ready. It advances the read pointer and sets level <= level - 1.
- Simultaneous push and pop:
  - The push is accepted even when the FIFO is full; level is unchanged.
  - If the FIFO is empty, no pop can occur, so only the push takes effect.
- underrun <= 1 in any cycle with out_ready=1 and out_valid=0, excluding reset and clear cycles.
- The FIFO is show-ahead. out_data always reflects the entry at the read pointer, is registered, and is stable while out_valid=1 and out_ready=0.
- Pointers are FIFO_LOG2 bits and wrap modulo D. Full and empty are distinguished by level, not by pointer equality.

## Timing
- Push latency: the word written at the clk edge where the Nth enable is sampled becomes visible (out_valid=1, out_data correct) on the following clk edge, i.e. 1 clk after the push edge.
- After a pop edge, the next entry (if any) is on out_data in the same cycle that out_valid is evaluated; there are no bubbles between back-to-back pops.
- level updates on the same edge as the push or pop.
- A new decimated sample is produced every N enables, i.e. every 64×(clk/3.072 MHz) clks.
- clk_3MHz_en adjacency: the block tolerates enables on consecutive clks (N enables in N clks).
- rst_n assertion mid-accumulation discards the partial sum. The first output after release requires a full N enables.
- clear asserted on the same cycle as a push edge: the push is lost and the FIFO ends empty.

## Test plan
- Silence: sound_enable=1, in_sample=0x8000 for 64 enables → one entry, out_data=0x0000, out_valid rises 1 clk after the 64th enable, level=1.
- Ramp and offset: in_sample = 0x8000+k for k=0..63 → out_data=0x001F (floor of 31.5). Then constant 0xC000 for 64 enables → next entry 0x4000; constant 0x0000 → 0x8000 (−32768).
- Overflow: out_ready=0, 9 periods of distinct constants → level=8, overflow=1, the first 8 values pop in order, and the 9th is absent.
- Full with simultaneous pop: level=8, out_ready=1 on the push edge → level stays 8, overflow stays 0, the new word is last in order.
- Reset mid-period: 30 enables of 0xFFFF, pulse rst_n low, then 64 enables of 0x8000 → single entry 0x0000. All outputs read reset values during rst_n low.
- Gating and flags: sound_enable=0 with in_sample=0xFFFF → 0x0000 pushed. out_ready=1 while empty → underrun=1 and it stays set until clear. clear → level=0, flags 0.
